// File: rtl/word_unpack_hl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : word_unpack_hl_pkg
//  Description : Shared types and width helpers for the high/low word
//                unpacker.
//  Revision    : 1.0 - initial release
// ============================================================================
package word_unpack_hl_pkg;

   // Unpacker sequencing: waiting for a word, emitting first half, emitting second half
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRST  = 2'd1,
      SECOND = 2'd2
   } unpack_state_t;

   // Half width of an N-bit word
   function automatic int half_width(input int n);
      return n / 2;
   endfunction

endpackage : word_unpack_hl_pkg
`default_nettype wire

// File: rtl/word_unpack_hl_if.sv
`default_nettype none
// ============================================================================
//  Module      : word_unpack_hl_if
//  Description : Word-in / half-out valid-ready stream bundle for the
//                high/low word unpacker.
//  Revision    : 1.0 - initial release
// ============================================================================
interface word_unpack_hl_if #(
   parameter int N = 16
);
   import word_unpack_hl_pkg::*;

   localparam int c_H = half_width(N);

   logic [N-1:0]   in_word;
   logic           in_lo_first;
   logic           in_valid;
   logic           in_ready;
   logic [c_H-1:0] out_half;
   logic           out_is_high;
   logic           out_last;
   logic           out_valid;
   logic           out_ready;

   // Environment side: drives words in and the sink's ready
   modport master (
      output in_word, in_lo_first, in_valid, out_ready,
      input  in_ready, out_half, out_is_high, out_last, out_valid
   );

   // Unpacker side
   modport slave (
      input  in_word, in_lo_first, in_valid, out_ready,
      output in_ready, out_half, out_is_high, out_last, out_valid
   );

endinterface : word_unpack_hl_if
`default_nettype wire

// File: rtl/word_unpack_hl_reg.sv
`default_nettype none
// ============================================================================
//  Module      : word_unpack_hl_reg
//  Description : Split high/low load register. Each half loads
//                independently; asynchronous active-high clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_unpack_hl_reg
   import word_unpack_hl_pkg::*;
#(
   parameter int N = 16
) (
   input  wire logic                    clk,
   input  wire logic                    clear,
   input  wire logic                    loadh,
   input  wire logic                    loadl,
   input  wire logic [half_width(N)-1:0] inh,
   input  wire logic [half_width(N)-1:0] inl,
   output logic      [N-1:0]            q
);

   localparam int c_H = half_width(N);

   logic [c_H-1:0] r_hi;
   logic [c_H-1:0] r_lo;

   // Upper half loads on loadh
   always_ff @(posedge clk or posedge clear) begin
      if (clear)      r_hi <= '0;
      else if (loadh) r_hi <= inh;
   end

   // Lower half loads on loadl
   always_ff @(posedge clk or posedge clear) begin
      if (clear)      r_lo <= '0;
      else if (loadl) r_lo <= inl;
   end

   assign q = {r_hi, r_lo};

endmodule : word_unpack_hl_reg
`default_nettype wire

// File: rtl/word_unpack_hl.sv
`default_nettype none
// ============================================================================
//  Module      : word_unpack_hl
//  Description : Accepts an N-bit word and emits it as two N/2-bit halves
//                over a valid/ready stream, high-first unless the word was
//                tagged low-first. One word per two cycles, back-to-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_unpack_hl
   import word_unpack_hl_pkg::*;
#(
   parameter int N  = 16,
   parameter int CW = 8
) (
   input  wire logic          clk,
   input  wire logic          clear_n,
   word_unpack_hl_if.slave    bus,
   output logic               busy,
   output logic [CW-1:0]      words_done
);

   localparam int c_H = half_width(N);

   unpack_state_t r_state;
   logic          r_lo_first;
   logic          r_valid;
   logic          r_last;
   logic          r_is_high;
   logic [CW-1:0] r_words_done;
   logic [N-1:0]  w_hold;
   logic          w_in_ready;
   logic          w_accept;
   logic          w_clear;

   // A new word is taken when idle, or when the second half leaves this
   // cycle; held low through reset so nothing is accepted while clearing.
   assign w_in_ready = clear_n &&
                       ((r_state == IDLE) || ((r_state == SECOND) && bus.out_ready));
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_clear    = ~clear_n;

   word_unpack_hl_reg #(
      .N (N)
   ) u_hold (
      .clk   (clk),
      .clear (w_clear),
      .loadh (w_accept),
      .loadl (w_accept),
      .inh   (bus.in_word[N-1:c_H]),
      .inl   (bus.in_word[c_H-1:0]),
      .q     (w_hold)
   );

   // Sequencer with registered handshake flags and completed-word counter
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_state      <= IDLE;
         r_lo_first   <= 1'b0;
         r_valid      <= 1'b0;
         r_last       <= 1'b0;
         r_is_high    <= 1'b0;
         r_words_done <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_state    <= FIRST;
                  r_lo_first <= bus.in_lo_first;
                  r_valid    <= 1'b1;
                  r_last     <= 1'b0;
                  r_is_high  <= ~bus.in_lo_first;
               end
            end
            FIRST: begin
               if (bus.out_ready) begin
                  r_state   <= SECOND;
                  r_last    <= 1'b1;
                  r_is_high <= r_lo_first;
               end
            end
            SECOND: begin
               if (bus.out_ready) begin
                  r_words_done <= r_words_done + 1'b1;
                  if (bus.in_valid) begin
                     r_state    <= FIRST;
                     r_lo_first <= bus.in_lo_first;
                     r_valid    <= 1'b1;
                     r_last     <= 1'b0;
                     r_is_high  <= ~bus.in_lo_first;
                  end else begin
                     r_state   <= IDLE;
                     r_valid   <= 1'b0;
                     r_last    <= 1'b0;
                     r_is_high <= 1'b0;
                  end
               end
            end
            default: begin
               r_state   <= IDLE;
               r_valid   <= 1'b0;
               r_last    <= 1'b0;
               r_is_high <= 1'b0;
            end
         endcase
      end
   end

   // Half select driven only by registered state; zero while idle
   always_comb begin
      bus.out_half = '0;
      if (r_valid) bus.out_half = r_is_high ? w_hold[N-1:c_H] : w_hold[c_H-1:0];
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = r_valid;
   assign bus.out_last    = r_last;
   assign bus.out_is_high = r_is_high;
   assign busy            = (r_state != IDLE);
   assign words_done      = r_words_done;

endmodule : word_unpack_hl
`default_nettype wire
